line_clear_ctrl: RTL and testbench

Sequences the existing 7x7 row-shifter to clear every full row of the fallen-pieces grid after a piece locks. It latches the grid on start, repeatedly finds the lowest full row, and drives the shifter to remove it. It writes each shifted grid back and stops when no full row remains. It sits between the piece-lock logic and the fallen-pieces register, and it also keeps the lines-cleared count and the running score.

---
 rtl/tetris_pkg.sv | 25 ++
 rtl/line_clear_ctrl_if.sv | 27 ++
 rtl/line_clear_ctrl_shifter.sv | 24 ++
 rtl/line_clear_ctrl.sv | 101 ++++++++++
 tb/tb_line_clear_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared grid geometry, controller state encoding and the full-row detector.
package tetris_pkg;

  localparam int NUM_ROWS  = 7;
  localparam int ROW_W     = 7;
  localparam int GRID_W    = NUM_ROWS * ROW_W;
  localparam int ROW_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit r is set when every cell of row r is occupied.
  function automatic logic [NUM_ROWS-1:0] full_row_mask(input logic [GRID_W-1:0] grid);
    logic [NUM_ROWS-1:0] mask;
    for (int r = 0; r < NUM_ROWS; r++) begin
      mask[r] = &grid[ROW_W*r +: ROW_W];
    end
    return mask;
  endfunction

endpackage

// File: rtl/line_clear_ctrl_if.sv
// Request/result bundle between the piece-lock logic and the line-clear controller.
interface line_clear_ctrl_if
  import tetris_pkg::*;
#(
  parameter int SCORE_W = 16
);

  logic                 start;
  logic [GRID_W-1:0]    grid_in;
  logic                 score_clr;
  logic                 busy;
  logic                 done;
  logic [GRID_W-1:0]    grid_out;
  logic [ROW_IDX_W-1:0] lines_cleared;
  logic [SCORE_W-1:0]   score;

  modport master (
    output start, grid_in, score_clr,
    input  busy, done, grid_out, lines_cleared, score
  );

  modport slave (
    input  start, grid_in, score_clr,
    output busy, done, grid_out, lines_cleared, score
  );

endinterface

// File: rtl/line_clear_ctrl_shifter.sv
// Combinational row remover: drops the selected row, shifts rows above it down one, fills row 0 with zeros.
// Transparent (new_grid = fallen_pieces) when not enabled.
module line_clear_ctrl_shifter
  import tetris_pkg::*;
(
  input  logic [GRID_W-1:0]    fallen_pieces,
  input  logic [ROW_IDX_W-1:0] row,
  input  logic                 enabled,
  output logic [GRID_W-1:0]    new_grid
);

  always_comb begin
    new_grid = fallen_pieces;
    if (enabled) begin
      new_grid[0 +: ROW_W] = '0;
      for (int r = 1; r < NUM_ROWS; r++) begin
        if (r <= int'(row)) begin
          new_grid[ROW_W*r +: ROW_W] = fallen_pieces[ROW_W*(r-1) +: ROW_W];
        end
      end
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// Clears every full row of a latched grid, one SCAN/CLEAR pair per row; done follows 2k+1 edges after start.
// Tracks rows removed per operation and a saturating running score.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int SCORE_W = 16
)(
  input  logic             clk,
  input  logic             reset,
  line_clear_ctrl_if.slave bus
);

  state_t               state;
  logic [GRID_W-1:0]    grid_q;
  logic [ROW_IDX_W-1:0] count;
  logic [ROW_IDX_W-1:0] row_sel;
  logic                 busy_q;
  logic                 done_q;
  logic [GRID_W-1:0]    grid_out_q;
  logic [ROW_IDX_W-1:0] lines_q;
  logic [SCORE_W-1:0]   score_q;

  logic [NUM_ROWS-1:0]  full;
  logic [ROW_IDX_W-1:0] sel_next;
  logic [GRID_W-1:0]    new_grid;

  // Later (higher-index) rows win, so the bottom-most full row is removed first.
  always_comb begin
    full     = full_row_mask(grid_q);
    sel_next = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (full[r]) sel_next = ROW_IDX_W'(r);
    end
  end

  line_clear_ctrl_shifter u_shifter (
    .fallen_pieces (grid_q),
    .row           (row_sel),
    .enabled       (state == CLEAR),
    .new_grid      (new_grid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grid_q     <= '0;
      count      <= '0;
      row_sel    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      grid_out_q <= '0;
      lines_q    <= '0;
      score_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            grid_q <= bus.grid_in;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (|full) begin
            row_sel <= sel_next;
            state   <= CLEAR;
          end else begin
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            grid_out_q <= grid_q;
            lines_q    <= count;
            state      <= DONE;
          end
        end
        CLEAR: begin
          grid_q <= new_grid;
          count  <= count + 1'b1;
          state  <= SCAN;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A clear request beats the increment from a coincident CLEAR cycle.
      if (bus.score_clr) begin
        score_q <= '0;
      end else if (state == CLEAR && score_q != {SCORE_W{1'b1}}) begin
        score_q <= score_q + 1'b1;
      end
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.grid_out      = grid_out_q;
  assign bus.lines_cleared = lines_q;
  assign bus.score         = score_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a queue of expected results checked on each done pulse.
module tb_line_clear_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  line_clear_ctrl_if #(.SCORE_W(16)) bus ();

  line_clear_ctrl #(.SCORE_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [48:0] grid;
    logic [2:0]  lines;
    logic [15:0] score;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  int   mscore = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] g7(input logic [6:0] r6, input logic [6:0] r5,
                                     input logic [6:0] r4, input logic [6:0] r3,
                                     input logic [6:0] r2, input logic [6:0] r1,
                                     input logic [6:0] r0);
    return {r6, r5, r4, r3, r2, r1, r0};
  endfunction

  // Reference: full rows vanish, surviving rows keep their order and settle at the bottom.
  function automatic void model(input logic [48:0] g, output logic [48:0] o, output int k);
    int          dst;
    logic [6:0]  row_bits;
    dst = 6;
    o   = '0;
    k   = 0;
    for (int r = 6; r >= 0; r--) begin
      row_bits = g[7*r +: 7];
      if (row_bits == 7'h7F) begin
        k++;
      end else begin
        o[7*dst +: 7] = row_bits;
        dst--;
      end
    end
  endfunction

  task automatic run_op(input string tag, input logic [48:0] g, input int abuse_at, input int clr_at);
    exp_t e;
    exp_t got;
    int   k;
    int   n;
    int   extra_done;
    bit   seen;
    model(g, e.grid, k);
    e.lines = 3'(k);
    if (clr_at >= 0) mscore = (k > 0) ? k - 1 : 0;
    else             mscore = (mscore + k > 16'hFFFF) ? 16'hFFFF : mscore + k;
    e.score = 16'(mscore);
    e.lat   = 2 * k + 1;
    sb.push_back(e);

    bus.grid_in = g;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.grid_in = ~g;
    check({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);

    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      bus.start     = (n == abuse_at);
      if (n == abuse_at) bus.grid_in = '1;
      bus.score_clr = (n == clr_at);
      tick();
      n++;
      bus.start     = 1'b0;
      bus.score_clr = 1'b0;
      if (bus.done) seen = 1'b1;
    end

    if (!seen) begin
      check({tag, "_done_timeout"}, 64'd0, 64'd1);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      check({tag, "_latency"},  64'(n),                  64'(got.lat));
      check({tag, "_grid_out"}, 64'(bus.grid_out),       64'(got.grid));
      check({tag, "_lines"},    64'(bus.lines_cleared),  64'(got.lines));
      check({tag, "_score"},    64'(bus.score),          64'(got.score));
      check({tag, "_busy_low"}, 64'(bus.busy),           64'd0);
    end

    tick();
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);

    if (abuse_at >= 0) begin
      extra_done = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus.done) extra_done++;
      end
      check({tag, "_single_done"}, 64'(extra_done), 64'd0);
    end
  endtask

  initial begin
    int extra_done;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.grid_in   = '0;
    bus.score_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_busy",  64'(bus.busy),          64'd0);
    check("rst_done",  64'(bus.done),          64'd0);
    check("rst_grid",  64'(bus.grid_out),      64'd0);
    check("rst_lines", 64'(bus.lines_cleared), 64'd0);
    check("rst_score", 64'(bus.score),         64'd0);

    run_op("single",  g7(7'h7F, 7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00), -1, -1);
    run_op("nonadj",  g7(7'h7F, 7'h00, 7'h2A, 7'h7F, 7'h00, 7'h00, 7'h00), -1, -1);
    run_op("nofull",  49'h1, -1, -1);
    run_op("allones", '1, -1, -1);
    run_op("mixed",   g7(7'h7F, 7'h7F, 7'h55, 7'h7F, 7'h3E, 7'h7F, 7'h01), -1, -1);
    run_op("abuse",   g7(7'h7F, 7'h11, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00), 2, -1);
    run_op("clrhit",  g7(7'h7F, 7'h22, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00), -1, 1);

    // Abort an all-ones clear while it sits in CLEAR.
    bus.grid_in = '1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    mscore = 0;
    check("abort_busy",  64'(bus.busy),     64'd0);
    check("abort_grid",  64'(bus.grid_out), 64'd0);
    check("abort_score", 64'(bus.score),    64'd0);
    check("abort_done",  64'(bus.done),     64'd0);
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) extra_done++;
    end
    check("abort_no_done", 64'(extra_done), 64'd0);

    // Preload the accumulator near its ceiling.
    force dut.score_q = 16'hFFFE;
    #1;
    release dut.score_q;
    mscore = 16'hFFFE;
    tick();
    check("preload_score", 64'(bus.score), 64'hFFFE);
    run_op("sat3",    g7(7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h00, 7'h00, 7'h00), -1, -1);
    run_op("sathold", '1, -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
